// File: rtl/imu_link_supervisor.sv
// IMU packet qualifier + link FSM (IDLE/ACQUIRE/LOCKED/STALE/FAULT); optional stats via IMU_SUPERVISOR_STATS_EN.
// Latency: state, counters and output register update on the edge sampling pkt_strobe (visible next cycle).
// Backpressure: one-entry newest-wins output register; an unaccepted sample is overwritten and counted in drop_count.
module imu_link_supervisor #(
    parameter int LOCK_COUNT     = 4,
    parameter int FAULT_COUNT    = 3,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_strobe,
    input  logic        pkt_hdr_ok,
    input  logic [1:0]  pkt_flags,
    input  logic [95:0] pkt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic [1:0]  out_flags,
    output logic [2:0]  link_state,
    output logic        link_ok,
    output logic [7:0]  drop_count,
    output logic [15:0] pkt_good_count,
    output logic [15:0] pkt_bad_count
);
    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]      LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0]      FAULT_N = 4'(FAULT_COUNT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACQ    = 3'd1,
        S_LOCKED = 3'd2,
        S_STALE  = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
    logic [3:0]      good_inc, bad_inc;
    logic [TW-1:0]   timer_q;
    logic            good, bad, tmo, fwd;

    assign good     = pkt_strobe & pkt_hdr_ok;
    assign bad      = pkt_strobe & ~pkt_hdr_ok;
    assign good_inc = (good_cnt_q == 4'hF) ? 4'hF : good_cnt_q + 4'd1;
    assign bad_inc  = (bad_cnt_q == 4'hF) ? 4'hF : bad_cnt_q + 4'd1;
    // Any strobe in the timeout cycle masks the timeout, even a bad one.
    assign tmo      = (timer_q == TMO_MAX) & ~pkt_strobe;
    // Decided on the current state, so the packet that completes lock is never forwarded.
    assign fwd      = good & (state_q == S_LOCKED) & (pkt_flags != 2'b00);

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (good) begin
            good_cnt_d = good_inc;
            bad_cnt_d  = 4'd0;
        end else if (bad) begin
            good_cnt_d = 4'd0;
            bad_cnt_d  = bad_inc;
        end

        if (bad && (bad_inc == FAULT_N)) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE, S_STALE, S_FAULT: begin
                    if (good) begin
                        if (LOCK_N == 4'd1) begin
                            state_d    = S_LOCKED;
                            good_cnt_d = 4'd0;
                        end else begin
                            state_d    = S_ACQ;
                            good_cnt_d = 4'd1;
                        end
                    end
                end
                S_ACQ: begin
                    if (good && (good_inc >= LOCK_N)) begin
                        state_d    = S_LOCKED;
                        good_cnt_d = 4'd0;
                    end else if (tmo) begin
                        state_d    = S_IDLE;
                        good_cnt_d = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (tmo) begin
                        state_d    = S_STALE;
                        good_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    good_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            good_cnt_q <= 4'd0;
            bad_cnt_q  <= 4'd0;
            timer_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= 96'd0;
            out_flags  <= 2'b00;
            drop_count <= 8'd0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            if (good) begin
                timer_q <= '0;
            end else if (timer_q != TMO_MAX) begin
                timer_q <= timer_q + TW'(1);
            end

            if (fwd) begin
                out_data  <= pkt_data;
                out_flags <= pkt_flags;
                out_valid <= 1'b1;
                if (out_valid && !out_ready && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign link_state = state_q;
    assign link_ok    = (state_q == S_LOCKED);

`ifdef IMU_SUPERVISOR_STATS_EN
    logic [15:0] good_stat_q, bad_stat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            good_stat_q <= 16'd0;
            bad_stat_q  <= 16'd0;
        end else begin
            if (good) good_stat_q <= good_stat_q + 16'd1;
            if (bad)  bad_stat_q  <= bad_stat_q + 16'd1;
        end
    end

    assign pkt_good_count = good_stat_q;
    assign pkt_bad_count  = bad_stat_q;
`else
    assign pkt_good_count = 16'd0;
    assign pkt_bad_count  = 16'd0;
`endif

endmodule

// File: tb/tb_imu_link_supervisor.sv
// Directed bench for imu_link_supervisor: lock-in, fault, timeout, backpressure, flags-zero and reset scenarios.
module tb_imu_link_supervisor;
    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_strobe;
    logic        pkt_hdr_ok;
    logic [1:0]  pkt_flags;
    logic [95:0] pkt_data;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [1:0]  out_flags;
    logic [2:0]  link_state;
    logic        link_ok;
    logic [7:0]  drop_count;
    logic [15:0] pkt_good_count;
    logic [15:0] pkt_bad_count;

    int          tests = 0;
    int          fails = 0;
    logic [97:0] exp_q[$];
    int          exp_drop = 0;

    always #5 clk = ~clk;

    imu_link_supervisor #(
        .LOCK_COUNT(4),
        .FAULT_COUNT(3),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pkt_strobe(pkt_strobe),
        .pkt_hdr_ok(pkt_hdr_ok),
        .pkt_flags(pkt_flags),
        .pkt_data(pkt_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_flags(out_flags),
        .link_state(link_state),
        .link_ok(link_ok),
        .drop_count(drop_count),
        .pkt_good_count(pkt_good_count),
        .pkt_bad_count(pkt_bad_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // fwd: the bench's own expectation that this packet reaches the output register.
    task automatic send(input logic hdr, input logic [1:0] flags, input logic [95:0] data, input logic fwd);
        pkt_strobe = 1'b1;
        pkt_hdr_ok = hdr;
        pkt_flags  = flags;
        pkt_data   = data;
        @(posedge clk);
        if (fwd) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                exp_drop++;
            end
            exp_q.push_back({flags, data});
        end
        #1;
        pkt_strobe = 1'b0;
        pkt_hdr_ok = 1'b0;
        pkt_flags  = 2'b00;
        pkt_data   = 96'd0;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Handshake monitor: every accepted sample must be the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 128'(out_valid), 128'(0));
            end else begin
                logic [97:0] e;
                e = exp_q.pop_front();
                check("handshake_sample", 128'({out_flags, out_data}), 128'(e));
            end
        end
    end

    initial begin
        logic [95:0] a, b, c, d;
        reset      = 1'b1;
        pkt_strobe = 1'b0;
        pkt_hdr_ok = 1'b0;
        pkt_flags  = 2'b00;
        pkt_data   = 96'd0;
        out_ready  = 1'b1;
        tick(3);
        reset = 1'b0;

        check("rst_state", 128'(link_state), 128'(0));
        check("rst_link_ok", 128'(link_ok), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_flags", 128'(out_flags), 128'(0));
        check("rst_drop", 128'(drop_count), 128'(0));
        check("rst_good_stat", 128'(pkt_good_count), 128'(0));
        check("rst_bad_stat", 128'(pkt_bad_count), 128'(0));

        // Lock-in
        send(1'b1, 2'd3, rnd96(), 1'b0);
        check("lock_p1_state", 128'(link_state), 128'(1));
        for (int i = 2; i <= 4; i++) begin
            tick(9);
            send(1'b1, 2'd3, rnd96(), 1'b0);
            check("lock_p_state", 128'(link_state), 128'(i == 4 ? 2 : 1));
        end
        check("lock_link_ok", 128'(link_ok), 128'(1));
        check("lock_no_fwd", 128'(out_valid), 128'(0));
        tick(9);
        a = rnd96();
        send(1'b1, 2'd3, a, 1'b1);
        check("p5_valid_latency", 128'(out_valid), 128'(1));
        check("p5_data", 128'(out_data), 128'(a));
        tick(1);
        check("p5_valid_drop", 128'(out_valid), 128'(0));

        // Flags zero restarts the timer
        tick(50);
        send(1'b1, 2'd0, rnd96(), 1'b0);
        tick(60);
        check("flags0_keepalive", 128'(link_state), 128'(2));
        check("flags0_no_fwd", 128'(out_valid), 128'(0));

        // Backpressure, newest wins
        out_ready = 1'b0;
        a = rnd96(); b = rnd96(); c = rnd96(); d = rnd96();
        send(1'b1, 2'd1, a, 1'b1); tick(2);
        send(1'b1, 2'd2, b, 1'b1); tick(2);
        send(1'b1, 2'd3, c, 1'b1); tick(2);
        check("bp_data_c", 128'(out_data), 128'(c));
        check("bp_flags_c", 128'(out_flags), 128'(3));
        check("bp_drop2", 128'(drop_count), 128'(exp_drop));
        check("bp_drop2_const", 128'(drop_count), 128'(2));
        send(1'b1, 2'd0, rnd96(), 1'b0);
        check("bp_flags0_valid", 128'(out_valid), 128'(1));
        check("bp_flags0_data", 128'(out_data), 128'(c));
        tick(2);
        out_ready = 1'b1;
        send(1'b1, 2'd2, d, 1'b1);
        check("hs_fwd_valid", 128'(out_valid), 128'(1));
        check("hs_fwd_data", 128'(out_data), 128'(d));
        check("hs_no_drop", 128'(drop_count), 128'(2));
        tick(2);
        check("hs_drained", 128'(out_valid), 128'(0));

        // Fault, then recovery, then interleaved good prevents fault
        send(1'b0, 2'd3, rnd96(), 1'b0); tick(2);
        check("fault_bad1", 128'(link_state), 128'(2));
        send(1'b0, 2'd3, rnd96(), 1'b0); tick(2);
        check("fault_bad2", 128'(link_state), 128'(2));
        check("bad_not_fwd", 128'(out_valid), 128'(0));
        send(1'b0, 2'd3, rnd96(), 1'b0);
        check("fault_bad3", 128'(link_state), 128'(4));
        tick(2);
        send(1'b1, 2'd3, rnd96(), 1'b0);
        check("fault_recover", 128'(link_state), 128'(1));
        repeat (3) begin tick(2); send(1'b1, 2'd3, rnd96(), 1'b0); end
        check("relock", 128'(link_state), 128'(2));
        tick(2); send(1'b0, 2'd0, rnd96(), 1'b0);
        tick(2); send(1'b0, 2'd0, rnd96(), 1'b0);
        tick(2); send(1'b1, 2'd0, rnd96(), 1'b0);
        tick(2); send(1'b0, 2'd0, rnd96(), 1'b0);
        check("interleave_no_fault", 128'(link_state), 128'(2));

        // Timeout boundary
        tick(2);
        send(1'b1, 2'd0, rnd96(), 1'b0);
        tick(99);
        check("tmo_c99", 128'(link_state), 128'(2));
        tick(1);
        check("tmo_c100", 128'(link_state), 128'(2));
        tick(1);
        check("tmo_c101_stale", 128'(link_state), 128'(3));
        check("tmo_link_ok", 128'(link_ok), 128'(0));
        send(1'b1, 2'd0, rnd96(), 1'b0);
        check("stale_recover", 128'(link_state), 128'(1));
        repeat (3) begin tick(2); send(1'b1, 2'd0, rnd96(), 1'b0); end
        check("relock2", 128'(link_state), 128'(2));
        tick(100);
        send(1'b1, 2'd0, rnd96(), 1'b0);
        check("strobe_at_c100", 128'(link_state), 128'(2));
        tick(1);
        check("strobe_at_c100_hold", 128'(link_state), 128'(2));

        // Reset mid-stream with pending output
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        out_ready = 1'b0;
        repeat (4) begin send(1'b1, 2'd0, rnd96(), 1'b0); tick(2); end
        a = rnd96(); b = rnd96();
        send(1'b0, 2'd0, rnd96(), 1'b0); tick(2);
        send(1'b1, 2'd1, a, 1'b1);       tick(2);
        send(1'b0, 2'd0, rnd96(), 1'b0); tick(2);
        send(1'b1, 2'd0, rnd96(), 1'b0); tick(2);
        send(1'b1, 2'd3, b, 1'b1);       tick(2);
        check("pre_rst_state", 128'(link_state), 128'(2));
        check("pre_rst_valid", 128'(out_valid), 128'(1));
        check("pre_rst_data", 128'(out_data), 128'(b));
        check("pre_rst_drop", 128'(drop_count), 128'(exp_drop));
`ifdef IMU_SUPERVISOR_STATS_EN
        check("stat_good7", 128'(pkt_good_count), 128'(7));
        check("stat_bad2", 128'(pkt_bad_count), 128'(2));
`else
        check("stat_good_off", 128'(pkt_good_count), 128'(0));
        check("stat_bad_off", 128'(pkt_bad_count), 128'(0));
`endif
        reset      = 1'b1;
        pkt_strobe = 1'b1;
        pkt_hdr_ok = 1'b1;
        pkt_flags  = 2'd3;
        pkt_data   = rnd96();
        tick(1);
        reset      = 1'b0;
        pkt_strobe = 1'b0;
        pkt_hdr_ok = 1'b0;
        pkt_flags  = 2'd0;
        pkt_data   = 96'd0;
        exp_q.delete();
        exp_drop = 0;
        check("mid_rst_state", 128'(link_state), 128'(0));
        check("mid_rst_link_ok", 128'(link_ok), 128'(0));
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_data", 128'(out_data), 128'(0));
        check("mid_rst_flags", 128'(out_flags), 128'(0));
        check("mid_rst_drop", 128'(drop_count), 128'(0));
        check("mid_rst_good_stat", 128'(pkt_good_count), 128'(0));
        check("mid_rst_bad_stat", 128'(pkt_bad_count), 128'(0));

        out_ready = 1'b1;
        tick(3);
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        check("final_valid", 128'(out_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imu_link_supervisor.md
# imu_link_supervisor

Supervises the sample stream from the Arduino SPI slave receiver. It qualifies each received packet and runs a link-state machine: idle, acquiring, locked, stale and fault. In the locked state it forwards valid sensor samples to the downstream consumer through a one-entry, newest-wins valid/ready output register. It sits in the `clk` domain between the SPI receive block's packet strobe and the motion/gesture logic.

## Interface
- `LOCK_COUNT`, 4: consecutive good packets required to reach LOCKED (range 1..15).
- `FAULT_COUNT`, 3: consecutive bad packets that force FAULT (range 1..15).
- `TIMEOUT_CYCLES`, 1200000: `clk` cycles without a good packet before a timeout (at least 2).
- `clk`  in  1  FPGA system clock. One clock; all logic on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `pkt_strobe`  in  1  One-cycle pulse per completed packet.
- `pkt_hdr_ok`  in  1  Header matched. Sampled only with `pkt_strobe`.
- `pkt_flags`  in  2  Bit 0 is Euler valid, bit 1 is gyro valid. Sampled with `pkt_strobe`.
- `pkt_data`  in  96  Roll, pitch, yaw, gyro x, y, z; 16 bits each, roll in [95:80].
- `out_valid`  out  1  Output sample available.
- `out_ready`  in  1  Consumer accepts the sample.
- `out_data`  out  96  Forwarded sample.
- `out_flags`  out  2  Flags of the forwarded sample.
- `link_state`  out  3  0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 STALE, 4 FAULT.
- `link_ok`  out  1  High when `link_state` is LOCKED.
- `drop_count`  out  8  Samples overwritten before being accepted. Saturates at 255.
- `pkt_good_count`, `pkt_bad_count`  out  16 each  Statistics; see Configuration.

## Operation
- Packet classification:
  - good = `pkt_strobe` & `pkt_hdr_ok`.
  - bad = `pkt_strobe` & !`pkt_hdr_ok`.
- Counters:
  - `good_cnt` (4 bits): incremented on good; cleared on bad and on any state entry not listed below.
  - `bad_cnt` (4 bits): incremented on bad; cleared on good.
  - Both saturate at 15.
- Timer:
  - Cleared to 0 on a good packet.
  - Otherwise increments each cycle, saturating at `TIMEOUT_CYCLES`.
  - `tmo` = (timer == `TIMEOUT_CYCLES`) & !`pkt_strobe`.
- Fault check, any state: a bad packet that brings `bad_cnt` to `FAULT_COUNT` goes to FAULT. This has priority over every other transition.
- IDLE:
  - Good packet: to ACQUIRE with `good_cnt`=1, or directly to LOCKED if `LOCK_COUNT`==1.
  - `tmo` is ignored.
- ACQUIRE:
  - Good packet: when `good_cnt`+1 reaches `LOCK_COUNT`, go to LOCKED.
  - Bad packet below the fault threshold: stay in ACQUIRE, `good_cnt`=0.
  - `tmo`: go to IDLE.
- LOCKED:
  - Good packet with `pkt_flags` != 0: forwarded.
  - Good packet with `pkt_flags` == 0: keeps the link alive, not forwarded.
  - Bad packet: never forwarded.
  - `tmo`: go to STALE.
- STALE and FAULT:
  - Good packet: to ACQUIRE with `good_cnt`=1 and `bad_cnt`=0, or to LOCKED if `LOCK_COUNT`==1.
  - `tmo` is ignored.
- Only packets arriving while already in LOCKED are forwarded. The packet that causes entry into LOCKED is not forwarded.
- Output register, newest wins:
  - Forward while `out_valid` & !`out_ready`: overwrite `out_data` and `out_flags`, keep `out_valid`=1, `drop_count`+1.
  - Forward in the same cycle as a handshake (`out_valid` & `out_ready`): load the new sample, `out_valid`=1, no drop.
  - Handshake with no forward: `out_valid`=0.
- Leaving LOCKED does not clear a pending output; it waits for a handshake.

## Timing
- Reset values:
  - `link_state`=0, `link_ok`=0, `out_valid`=0, `out_data`=0, `out_flags`=0, `drop_count`=0.
  - Statistics counters = 0.
  - Internal counters and timer = 0.
- Latency:
  - State, counters and output register update on the edge that samples `pkt_strobe`, so they are visible the next cycle.
  - `out_valid` rises 1 cycle after a forwarded strobe.
- Timeout timing: the timer reaches `TIMEOUT_CYCLES` exactly `TIMEOUT_CYCLES` cycles after the last good packet. The state changes on the following edge.
- A strobe in the same cycle as a would-be timeout suppresses the timeout.
- `reset` mid-operation, including with `out_valid` high: returns everything to reset values on that edge. Nothing is forwarded on that edge.
- `pkt_strobe` is assumed never to be high on consecutive cycles. The block stays correct if it is: each cycle is processed independently.

## Configuration
- `IMU_SUPERVISOR_STATS_EN` defined: `pkt_good_count` and `pkt_bad_count` count good and bad packets, wrapping modulo 2^16, cleared by `reset`.
- `IMU_SUPERVISOR_STATS_EN` undefined: no counter logic; both ports are driven constant 0.

## Test plan
All scenarios use `LOCK_COUNT`=4, `FAULT_COUNT`=3, `TIMEOUT_CYCLES`=100.
- Lock-in: 5 good packets, flags=3, spaced 10 cycles → `link_state` 1 after packet 1, 2 after packet 4; only packet 5 appears on `out_data`; `out_valid` high 1 cycle after packet 5's strobe.
- Fault: in LOCKED send 3 bad packets → `link_state`=4 after the third. Then 1 good packet → 1. An interleaved good packet after 2 bad prevents the fault.
- Timeout: in LOCKED, no strobe → `link_state`=3 at cycle 101 after the last good packet. A good strobe at exactly cycle 100 keeps LOCKED.
- Backpressure: `out_ready`=0, 3 forwarded samples A, B, C → `out_data`=C, `drop_count`=2. A new sample in the same cycle as a handshake → no drop increment.
- Flags zero: in LOCKED, good packet with flags=0 → timer restarts, `out_valid` unchanged.
- Reset mid-stream: assert `reset` with `out_valid`=1 and state LOCKED → all outputs 0 next cycle. With `IMU_SUPERVISOR_STATS_EN`, counts of 7 good and 2 bad read back before reset.
